// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART transmit and receive paths.
//   uart_state_t       frame-level FSM state (IDLE, START, DATA, STOP)
//   UART_DATA_WIDTH    default data bits per frame
//   UART_CLKS_PER_BIT  default clk cycles per serial bit (100 MHz / 115200 baud)
//   START_BIT          line level of the start bit
//   STOP_BIT           line level of the stop bit, which is also the idle level
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int UART_DATA_WIDTH   = 8;
    localparam int UART_CLKS_PER_BIT = 868;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_piso.sv
// piso_unit: parallel-in / serial-out shift register for the UART transmitter.
//   clk         in   system clock, rising edge
//   reset       in   synchronous, active-high; clears the register
//   load        in   capture d into the register (wins over shift)
//   shift       in   shift the register one place toward the LSB
//   d           in   WIDTH-bit parallel word
//   serial_out  out  current LSB of the register
module piso_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             serial_out
);

    logic [WIDTH-1:0] q;

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (shift) begin
            q <= q >> 1;
        end
    end

    assign serial_out = q[0];

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter. Takes a byte over a valid/ready handshake and sends
// it as one start bit, DATA_WIDTH data bits LSB first and one stop bit, each
// lasting CLKS_PER_BIT cycles. No parity.
//   clk       in   system clock, rising edge
//   reset     in   synchronous, active-high; aborts any frame in progress
//   tx_data   in   byte to send, captured on the accepting edge only
//   tx_valid  in   tx_data holds a byte to send
//   tx_ready  out  a byte can be accepted this cycle (IDLE or last STOP cycle)
//   tx        out  serial line, idle high, registered
//   busy      out  a frame is in progress
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = UART_DATA_WIDTH,
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx,
    output logic                  busy
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_WIDTH + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

    uart_state_t       state;
    uart_state_t       state_next;
    logic [BAUD_W-1:0] baud_cnt;
    logic [BIT_W-1:0]  bit_idx;

    logic bit_done;
    logic last_bit;
    logic accept;
    logic load;
    logic shift;
    logic serial_bit;
    logic tx_next;

    assign bit_done = (baud_cnt == BAUD_LAST);
    assign last_bit = (bit_idx == BIT_LAST);
    assign accept   = tx_valid && tx_ready;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = START;
            START:   if (bit_done) state_next = DATA;
            DATA:    if (bit_done && last_bit) state_next = STOP;
            STOP:    if (bit_done) state_next = accept ? START : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output / datapath control. Accepting in the last STOP cycle chains the
    // next start bit straight onto the stop bit, so back-to-back frames have
    // no idle gap.
    always_comb begin
        tx_ready = (state == IDLE) || ((state == STOP) && bit_done);
        busy     = (state != IDLE);
        load     = accept;
        // The first data bit leaves the shifter at the end of START, so the
        // register runs one bit ahead of the line from then on.
        shift    = bit_done && ((state == START) || (state == DATA));
        tx_next  = tx;
        unique case (state)
            IDLE:    if (accept) tx_next = START_BIT;
            START:   if (bit_done) tx_next = serial_bit;
            DATA:    if (bit_done) tx_next = last_bit ? STOP_BIT : serial_bit;
            STOP:    if (bit_done && accept) tx_next = START_BIT;
            default: tx_next = STOP_BIT;
        endcase
    end

    // Baud counter, bit index and line register. The baud counter rests at 0
    // in IDLE so a new frame's start bit always gets its full CLKS_PER_BIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= STOP_BIT;
        end else begin
            tx <= tx_next;
            if ((state == IDLE) || bit_done) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
            if ((state == START) && bit_done) begin
                bit_idx <= '0;
            end else if ((state == DATA) && bit_done) begin
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

    piso_unit #(
        .WIDTH(DATA_WIDTH)
    ) u_piso (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .shift     (shift),
        .d         (tx_data),
        .serial_out(serial_bit)
    );

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed, table-driven bench for uart_tx with CLKS_PER_BIT=4,
// DATA_WIDTH=8. Expected frames are written out by hand as 10-bit line
// patterns, bit 0 = start bit, bit 9 = stop bit, in transmission order.
module tb_uart_tx;

    localparam int DW  = 8;
    localparam int CPB = 4;

    logic          clk;
    logic          reset;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          tx;
    logic          busy;

    int n_vec;
    int n_miss;

    typedef struct {
        string       name;
        logic [7:0]  data;
        logic [9:0]  frame;
    } vec_t;

    vec_t vecs [6];

    uart_tx #(
        .DATA_WIDTH  (DW),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx      (tx),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            chk({tag, " idle tx"}, tx, 1'b1);
            chk({tag, " idle ready"}, tx_ready, 1'b1);
            chk({tag, " idle busy"}, busy, 1'b0);
            tick();
        end
    endtask

    // Present a byte in IDLE and let the next edge accept it. The data bus is
    // then scrambled to show that only the accepting edge samples it.
    task automatic start_frame(input logic [7:0] data, input bit hold, input string tag);
        tx_valid = 1'b1;
        tx_data  = data;
        chk({tag, " ready before accept"}, tx_ready, 1'b1);
        tick();
        if (!hold) tx_valid = 1'b0;
        tx_data = ~data;
    endtask

    // Check n_cyc cycles of a frame, one sample per cycle. pulse_at injects a
    // one-cycle tx_valid=1 with 0xFF mid-frame; hold keeps tx_valid asserted
    // into the last stop cycle.
    task automatic check_frame(input logic [9:0] frame, input int n_cyc,
                               input int pulse_at, input bit hold, input string tag);
        for (int i = 0; i < n_cyc; i++) begin
            chk({tag, " tx"}, tx, frame[i / CPB]);
            chk({tag, " busy"}, busy, 1'b1);
            chk({tag, " ready"}, tx_ready, (i == 10 * CPB - 1));
            if (i == pulse_at) begin
                tx_valid = 1'b1;
                tx_data  = 8'hFF;
            end else if (i == pulse_at + 1) begin
                tx_valid = 1'b0;
            end
            if ((i == 10 * CPB - 1) && !hold) tx_valid = 1'b0;
            tick();
        end
    endtask

    initial begin
        n_vec    = 0;
        n_miss   = 0;
        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = '0;

        vecs[0] = '{"A5", 8'hA5, 10'b1101001010};
        vecs[1] = '{"81", 8'h81, 10'b1100000010};
        vecs[2] = '{"3C", 8'h3C, 10'b1001111000};
        vecs[3] = '{"5A", 8'h5A, 10'b1010110100};
        vecs[4] = '{"00", 8'h00, 10'b1000000000};
        vecs[5] = '{"FF", 8'hFF, 10'b1111111110};

        // Reset held three cycles, then released
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset tx", tx, 1'b1);
            chk("reset ready", tx_ready, 1'b1);
            chk("reset busy", busy, 1'b0);
        end
        reset = 1'b0;
        tick();
        chk_idle("post-reset", 3);

        // Single frames from the table; includes 0xA5 and the single-pulse 0x81
        foreach (vecs[k]) begin
            start_frame(vecs[k].data, 1'b0, {"frame ", vecs[k].name});
            check_frame(vecs[k].frame, 10 * CPB, -10, 1'b0, {"frame ", vecs[k].name});
            chk_idle({"after ", vecs[k].name}, 4);
        end

        // Single-cycle pulse with 0x81: exactly one frame, then idle for good
        start_frame(8'h81, 1'b0, "pulse 81");
        check_frame(10'b1100000010, 10 * CPB, -10, 1'b0, "pulse 81");
        chk_idle("pulse 81", 20);

        // Back-to-back: tx_valid held, 0x00 then 0xFF, no gap, busy stays high
        start_frame(8'h00, 1'b1, "b2b 00");
        tx_data = 8'hFF;
        check_frame(10'b1000000000, 10 * CPB, -10, 1'b1, "b2b 00");
        check_frame(10'b1111111110, 10 * CPB, -10, 1'b0, "b2b FF");
        chk_idle("b2b", 4);

        // Mid-frame tx_valid pulse with 0xFF is ignored
        start_frame(8'h5A, 1'b0, "ignore 5A");
        check_frame(10'b1010110100, 10 * CPB, 10, 1'b0, "ignore 5A");
        chk_idle("ignore", 10);

        // Reset during data bit 3 of 0xC3 (line slot 4), then a clean 0x3C
        start_frame(8'hC3, 1'b0, "abort C3");
        check_frame(10'b1110000110, 4 * CPB + 2, -10, 1'b0, "abort C3");
        reset = 1'b1;
        tick();
        chk("abort tx", tx, 1'b1);
        chk("abort ready", tx_ready, 1'b1);
        chk("abort busy", busy, 1'b0);
        reset = 1'b0;
        tick();
        chk_idle("after abort", 3);
        start_frame(8'h3C, 1'b0, "resume 3C");
        check_frame(10'b1001111000, 10 * CPB, -10, 1'b0, "resume 3C");
        chk_idle("after 3C", 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
